// File: rtl/detect_scheduler.sv
// detect_scheduler: round-robin arbiter that time-shares one serial two-equal-bits
// Moore detector between NREQ bit-stream requesters. Each grant runs a fixed frame:
// CLR (clear detector), SHIFT (FRAME_LEN bits steered in), DRAIN (2 cycles), DONE.
// Latency: request seen in IDLE at cycle t -> done_o at t+4+FRAME_LEN.
// Backpressure: none; req_i is only sampled in IDLE and a started frame always completes.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   req_i        level request per requester
//   req_bit_i    serial data per requester, used only while that requester is granted
//   gnt_o        one-hot grant, high during the FRAME_LEN SHIFT cycles
//   det_in_o     detector inbit (combinational mux of the granted requester's bit)
//   det_clr_o    detector reset
//   det_hit_i    detector registered detect output
//   done_o       one-cycle pulse when done_id_o / match_cnt_o carry a new result
//   done_id_o    requester served in the reported frame
//   match_cnt_o  detector hits counted over the reported frame
//   busy_o       high whenever the scheduler is not IDLE
module detect_scheduler #(
    parameter int NREQ      = 4,
    parameter int ID_W      = 2,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ-1:0]  req_bit_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic             det_in_o,
    output logic             det_clr_o,
    input  logic             det_hit_i,
    output logic             done_o,
    output logic [ID_W-1:0]  done_id_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             busy_o
);

    localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             drain_q, drain_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [CNT_W-1:0] match_q, match_d;
    // Keeps the detector cleared for one cycle past reset release, without a
    // combinational path from reset_i to det_clr_o.
    logic             clr_hold_q;

    // Round-robin pick: first requester found walking upward from the pointer.
    // NREQ is a power of two, so the ID_W-bit index wraps naturally.
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  idx;
    logic             found;

    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr_q + ID_W'(i);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Hit counter including this cycle's detector output; also used to load the
    // result so a hit in the last DRAIN cycle is not lost.
    logic [CNT_W-1:0] hit_inc;
    assign hit_inc = hit_cnt_q + {{(CNT_W-1){1'b0}}, det_hit_i};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        drain_d   = drain_q;
        hit_cnt_d = hit_cnt_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        done_id_d = done_id_q;
        match_d   = match_q;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    id_d    = win;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                hit_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                hit_cnt_d = hit_inc;
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(FRAME_LEN - 1)) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                hit_cnt_d = hit_inc;
                drain_d   = 1'b1;
                if (drain_q) begin
                    done_id_d = id_q;
                    match_d   = hit_inc;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = id_q + ID_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            drain_q    <= 1'b0;
            hit_cnt_q  <= '0;
            ptr_q      <= '0;
            id_q       <= '0;
            done_id_q  <= '0;
            match_q    <= '0;
            clr_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            drain_q    <= drain_d;
            hit_cnt_q  <= hit_cnt_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            done_id_q  <= done_id_d;
            match_q    <= match_d;
            clr_hold_q <= 1'b0;
        end
    end

    // All control outputs decode registered state; only det_in_o passes data through.
    assign gnt_o       = (state_q == S_SHIFT) ? (NREQ'(1) << id_q) : '0;
    assign det_in_o    = (state_q == S_SHIFT) & req_bit_i[id_q];
    assign det_clr_o   = (state_q == S_CLR) | clr_hold_q;
    assign done_o      = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_id_o   = done_id_q;
    assign match_cnt_o = match_q;

endmodule
